// File: rtl/dsp_seq_pkg.sv
// Shared types and constants for the DSP48A1 dot-product sequencer.
// The slice runs with A1/B1, M, OPMODE and P registers enabled, so an
// operand pair needs three clocks to reach P; the tag pipe is one deeper
// so its last stage lines up with a valid P output.
package dsp_seq_pkg;

    localparam int DATA_W     = 18;
    localparam int P_W        = 48;
    localparam int SLICE_LAT  = 3;
    localparam int TAG_W      = 2;              // {first, last}
    localparam int PIPE_DEPTH = SLICE_LAT + 1;  // s1..s4

    // X = M, Z = 0: start a new sum
    localparam logic [7:0] OPM_LOAD = 8'h01;
    // X = M, Z = P: accumulate
    localparam logic [7:0] OPM_ACC  = 8'h09;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } seq_state_t;

    // One tag travels alongside every accepted operand pair
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

    // The first pair of a vector overwrites P, later pairs add into it
    function automatic logic [7:0] opmode_for(input logic first);
        return first ? OPM_LOAD : OPM_ACC;
    endfunction

endpackage

// File: rtl/dsp_dot_sequencer_if.sv
// Operand-in and result-out valid/ready channels of the dot sequencer.
// master = operand source / result consumer, slave = the sequencer.
interface dsp_dot_sequencer_if;
    import dsp_seq_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              res_valid;
    logic              res_ready;
    logic [P_W-1:0]    res_data;

    modport master (
        output in_valid, in_a, in_b, res_ready,
        input  in_ready, res_valid, res_data
    );

    modport slave (
        input  in_valid, in_a, in_b, res_ready,
        output in_ready, res_valid, res_data
    );

endinterface

// File: rtl/dsp_tag_pipe.sv
// Four-stage tag shift register that shadows an operand pair through the
// DSP slice. Stage n is valid exactly in the cycle the slice needs its
// stage-n clock enable for that pair. It shifts every clock, so bubbles
// simply travel through as invalid tags.
module dsp_tag_pipe
    import dsp_seq_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  tag_t i_tag,
    output tag_t o_s1,
    output tag_t o_s2,
    output tag_t o_s3,
    output tag_t o_s4
);

    // w_chain[0] is the incoming tag, w_chain[n] is stage n
    logic [PIPE_DEPTH:0][TAG_W:0] w_chain;

    assign w_chain[0] = i_tag;

    generate
        for (genvar gi = 1; gi <= PIPE_DEPTH; gi++) begin : g_stage
            logic [TAG_W:0] r_stage;

            // Unconditional advance of one stage per clock
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_stage <= '0;
                end else begin
                    r_stage <= w_chain[gi-1];
                end
            end

            assign w_chain[gi] = r_stage;
        end
    endgenerate

    assign o_s1 = tag_t'(w_chain[1]);
    assign o_s2 = tag_t'(w_chain[2]);
    assign o_s3 = tag_t'(w_chain[3]);
    assign o_s4 = tag_t'(w_chain[4]);

endmodule

// File: rtl/dsp_dot_sequencer.sv
// Control stage for one DSP48A1 slice: accepts VEC_LEN signed operand
// pairs, steers the slice clock enables and OPMODE so P accumulates their
// products, then returns the 48-bit sum as a single result beat.
module dsp_dot_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int VEC_LEN = 8,
    parameter int CNT_W   = $clog2(VEC_LEN + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    dsp_dot_sequencer_if.slave  s_if,
    output logic [DATA_W-1:0]   dsp_a,
    output logic [DATA_W-1:0]   dsp_b,
    output logic [7:0]          dsp_opmode,
    output logic                dsp_ceab,
    output logic                dsp_cem,
    output logic                dsp_cep,
    output logic                dsp_rst,
    input  logic [P_W-1:0]      dsp_p,
    output logic                busy
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

    seq_state_t        r_state;
    seq_state_t        w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_in_ready;
    logic              w_res_valid;
    logic              w_capture;
    logic              w_accept;
    logic              w_first;
    logic              w_last;

    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [7:0]        r_opmode;
    logic [P_W-1:0]    r_res_data;
    logic              r_dsp_rst;

    tag_t              w_tag_in;
    tag_t              w_s1;
    tag_t              w_s2;
    tag_t              w_s3;
    tag_t              w_s4;
    logic              w_unused_tag;

    // Beat position inside the current vector
    assign w_accept = w_in_ready & s_if.in_valid;
    assign w_first  = (r_cnt == '0);
    assign w_last   = (r_cnt == LAST_IDX);

    // FSM state and beat counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state, counter update and handshake outputs
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_in_ready   = 1'b0;
        w_res_valid  = 1'b0;
        w_capture    = 1'b0;
        unique case (r_state)
            IDLE, FEED: begin
                w_in_ready = 1'b1;
                if (s_if.in_valid) begin
                    w_cnt_next   = r_cnt + CNT_W'(1);
                    w_state_next = (r_cnt == LAST_IDX) ? DRAIN : FEED;
                end
            end
            DRAIN: begin
                // Last pair's tag in s4 means P now holds the full sum
                if (w_s4.valid && w_s4.last) begin
                    w_capture    = 1'b1;
                    w_state_next = OUT;
                end
            end
            OUT: begin
                w_res_valid = 1'b1;
                if (s_if.res_ready) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Tag entering s1 together with the operands it describes
    always_comb begin
        w_tag_in       = '0;
        w_tag_in.valid = w_accept;
        w_tag_in.first = w_accept & w_first;
        w_tag_in.last  = w_accept & w_last;
    end

    dsp_tag_pipe u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .i_tag (w_tag_in),
        .o_s1  (w_s1),
        .o_s2  (w_s2),
        .o_s3  (w_s3),
        .o_s4  (w_s4)
    );

    // Operand registers feeding the slice A/B pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;
            r_b <= '0;
        end else if (w_accept) begin
            r_a <= s_if.in_a;
            r_b <= s_if.in_b;
        end
    end

    // Last OPMODE presented, held while no tag sits in s2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opmode <= '0;
        end else if (w_s2.valid) begin
            r_opmode <= opmode_for(w_s2.first);
        end
    end

    // Result register, loaded from P on the DRAIN -> OUT transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_data <= '0;
        end else if (w_capture) begin
            r_res_data <= dsp_p;
        end
    end

    // Slice reset stays high one clock past rst_n release so the slice's
    // synchronous resets see at least one edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dsp_rst <= 1'b1;
        end else begin
            r_dsp_rst <= 1'b0;
        end
    end

    assign dsp_a      = r_a;
    assign dsp_b      = r_b;
    assign dsp_ceab   = w_s1.valid;
    assign dsp_cem    = w_s2.valid;
    assign dsp_cep    = w_s3.valid;
    assign dsp_opmode = w_s2.valid ? opmode_for(w_s2.first) : r_opmode;
    assign dsp_rst    = r_dsp_rst;
    assign busy       = (r_state != IDLE);

    assign s_if.in_ready  = w_in_ready;
    assign s_if.res_valid = w_res_valid;
    assign s_if.res_data  = r_res_data;

    // Tag bits that only matter at other stages
    assign w_unused_tag = ^{w_s1.first, w_s1.last, w_s2.last,
                            w_s3.first, w_s3.last, w_s4.first};

endmodule
